// File: rtl/mul_div_unit.sv
// Iterative signed multiply / divide unit: one bit per cycle on operand magnitudes,
// sign applied in a final FIX cycle. MUL, MULH, DIV and REM share one 2*XLEN accumulator.
module mul_div_unit #(
    parameter int XLEN = 32
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            start_i,
    input  logic [1:0]      op_i,
    input  logic [XLEN-1:0] data1_i,
    input  logic [XLEN-1:0] data2_i,
    output logic [XLEN-1:0] data_o,
    output logic            busy_o,
    output logic            done_o
);

    localparam int CNT_W = (XLEN > 1) ? $clog2(XLEN) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(XLEN - 1);

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        CALC = 2'b01,
        FIX  = 2'b10,
        DONE = 2'b11
    } state_t;

    typedef enum logic [1:0] {
        OP_MUL  = 2'b00,
        OP_MULH = 2'b01,
        OP_DIV  = 2'b10,
        OP_REM  = 2'b11
    } op_t;

    state_t            state, state_next;
    op_t               op_q;
    logic [CNT_W-1:0]  cnt_q;
    logic              neg_q;
    logic              div0_q;
    logic [XLEN-1:0]   opnd_q;
    logic [XLEN-1:0]   data1_q;
    logic [2*XLEN-1:0] acc_q;

    // Operand decode at acceptance.
    logic            sign1, sign2, is_mul, is_div0;
    logic [XLEN-1:0] mag1, mag2;

    assign sign1   = data1_i[XLEN-1];
    assign sign2   = data2_i[XLEN-1];
    assign mag1    = sign1 ? -data1_i : data1_i;
    assign mag2    = sign2 ? -data2_i : data2_i;
    assign is_mul  = ~op_i[1];
    assign is_div0 = op_i[1] && (data2_i == '0);

    assign busy_o = (state == CALC) || (state == FIX);
    assign done_o = (state == DONE);

    // One iteration step. Multiply: acc = {partial_hi, multiplier}, shift right.
    // Divide: acc = {remainder, dividend/quotient}, shift left with trial subtract.
    logic [XLEN:0]     mul_sum;
    logic [XLEN:0]     rem_shift;
    logic [XLEN:0]     div_diff;
    logic [2*XLEN-1:0] acc_step;

    always_comb begin
        // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
        acc_step  = acc_q;
        mul_sum   = {1'b0, acc_q[2*XLEN-1:XLEN]} + (acc_q[0] ? {1'b0, opnd_q} : '0);
        rem_shift = {acc_q[2*XLEN-1:XLEN], acc_q[XLEN-1]};
        div_diff  = rem_shift - {1'b0, opnd_q};
        if (!op_q[1]) begin
            acc_step = {mul_sum, acc_q[XLEN-1:1]};
        end else if (div_diff[XLEN]) begin
            acc_step = {rem_shift[XLEN-1:0], acc_q[XLEN-2:0], 1'b0};
        end else begin
            acc_step = {div_diff[XLEN-1:0], acc_q[XLEN-2:0], 1'b1};
        end
    end

    // Sign fix-up and result selection; the full product is negated before slicing.
    logic [2*XLEN-1:0] prod_signed;
    logic [XLEN-1:0]   quo_signed;
    logic [XLEN-1:0]   rem_signed;
    logic [XLEN-1:0]   result;

    always_comb begin
        prod_signed = neg_q ? -acc_q : acc_q;
        quo_signed  = neg_q ? -acc_q[XLEN-1:0] : acc_q[XLEN-1:0];
        rem_signed  = neg_q ? -acc_q[2*XLEN-1:XLEN] : acc_q[2*XLEN-1:XLEN];
        result      = '0;
        case (op_q)
            OP_MUL:  result = prod_signed[XLEN-1:0];
            OP_MULH: result = prod_signed[2*XLEN-1:XLEN];
            OP_DIV:  result = div0_q ? '1 : quo_signed;
            OP_REM:  result = div0_q ? data1_q : rem_signed;
        endcase
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE: if (start_i) state_next = is_div0 ? FIX : CALC;
            CALC: if (cnt_q == CNT_LAST) state_next = FIX;
            FIX:  state_next = DONE;
            DONE: state_next = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk_i) begin
        if (rst_i) state <= IDLE;
        else       state <= state_next;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            // NOTE: datapath registers are cleared as well so an aborted operation leaves no stale operands.
            op_q    <= OP_MUL;
            cnt_q   <= '0;
            neg_q   <= 1'b0;
            div0_q  <= 1'b0;
            opnd_q  <= '0;
            data1_q <= '0;
            acc_q   <= '0;
            data_o  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start_i) begin
                        op_q    <= op_t'(op_i);
                        neg_q   <= (op_i == OP_REM) ? sign1 : (sign1 ^ sign2);
                        div0_q  <= is_div0;
                        data1_q <= data1_i;
                        opnd_q  <= is_mul ? mag1 : mag2;
                        acc_q   <= {{XLEN{1'b0}}, (is_mul ? mag2 : mag1)};
                        cnt_q   <= '0;
                    end
                end
                CALC: begin
                    acc_q <= acc_step;
                    cnt_q <= (cnt_q == CNT_LAST) ? '0 : cnt_q + 1'b1;
                end
                FIX: data_o <= result;
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_mul_div_unit.sv
// Self-checking bench for mul_div_unit: directed corner cases, busy/restart and
// reset behaviour, then randomized operations against a 64-bit arithmetic model.
module tb_mul_div_unit;

    localparam int XLEN = 32;
    localparam logic [1:0] OP_MUL  = 2'b00;
    localparam logic [1:0] OP_MULH = 2'b01;
    localparam logic [1:0] OP_DIV  = 2'b10;
    localparam logic [1:0] OP_REM  = 2'b11;

    logic            clk_i = 1'b0;
    logic            rst_i;
    logic            start_i;
    logic [1:0]      op_i;
    logic [XLEN-1:0] data1_i;
    logic [XLEN-1:0] data2_i;
    logic [XLEN-1:0] data_o;
    logic            busy_o;
    logic            done_o;

    int checks = 0;
    int passed = 0;

    mul_div_unit #(.XLEN(XLEN)) dut (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .start_i (start_i),
        .op_i    (op_i),
        .data1_i (data1_i),
        .data2_i (data2_i),
        .data_o  (data_o),
        .busy_o  (busy_o),
        .done_o  (done_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got === exp) passed++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    // Reference: exact signed arithmetic in 64 bits, truncated to XLEN.
    function automatic logic [31:0] model(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
        longint sa, sb, r;
        logic [63:0] p;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        case (op)
            OP_MUL:  begin r = sa * sb; p = r; return p[31:0]; end
            OP_MULH: begin r = sa * sb; p = r; return p[63:32]; end
            OP_DIV:  begin
                if (b == 0) return 32'hFFFF_FFFF;
                r = sa / sb; p = r; return p[31:0];
            end
            default: begin
                if (b == 0) return a;
                r = sa % sb; p = r; return p[31:0];
            end
        endcase
    endfunction

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 7))
            0: return 32'h0000_0000;
            1: return 32'h0000_0001;
            2: return 32'hFFFF_FFFF;
            3: return 32'h8000_0000;
            4: return 32'h7FFF_FFFF;
            default: return $urandom;
        endcase
    endfunction

    // Accepts one operation and follows it to DONE and one cycle beyond.
    task automatic run_op(input string tag, input logic [1:0] op, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] exp, input int lat,
                          input bit noise);
        int done_at;
        int busy_n;
        op_i = op; data1_i = a; data2_i = b; start_i = 1'b1;
        step();
        start_i = 1'b0;
        done_at = 0;
        busy_n  = 0;
        for (int k = 1; k <= 80 && done_at == 0; k++) begin
            if (busy_o) busy_n++;
            if (done_o) begin
                done_at = k;
                check({tag, " data"}, data_o, exp);
            end
            if (noise && (busy_o || done_o)) begin
                start_i = 1'($urandom_range(0, 1));
                op_i    = 2'($urandom_range(0, 3));
                data1_i = $urandom;
                data2_i = $urandom;
            end else begin
                start_i = 1'b0;
            end
            step();
        end
        start_i = 1'b0;
        check({tag, " done cycle"}, 32'(done_at), 32'(lat));
        check({tag, " busy cycles"}, 32'(busy_n), 32'(lat - 1));
        check({tag, " held data"}, data_o, exp);
        check({tag, " done pulse"}, {31'b0, done_o}, 32'h0);
    endtask

    initial begin
        int first_at, second_at, done_cnt;
        logic [31:0] first_data, second_data;
        logic [1:0] op;
        logic [31:0] a, b;

        rst_i = 1'b1; start_i = 1'b0; op_i = '0; data1_i = '0; data2_i = '0;
        step();
        step();
        check("reset data", data_o, 32'h0);
        check("reset busy", {31'b0, busy_o}, 32'h0);
        check("reset done", {31'b0, done_o}, 32'h0);
        rst_i = 1'b0;

        run_op("mul 7x-3",      OP_MUL,  32'h0000_0007, 32'hFFFF_FFFD, 32'hFFFF_FFEB, 34, 1'b0);
        run_op("mulh min*min",  OP_MULH, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 34, 1'b0);
        run_op("mulh -1*1",     OP_MULH, 32'hFFFF_FFFF, 32'h0000_0001, 32'hFFFF_FFFF, 34, 1'b0);
        run_op("div -7/2",      OP_DIV,  32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFD, 34, 1'b0);
        run_op("rem -7%2",      OP_REM,  32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF, 34, 1'b0);
        run_op("rem 7%-2",      OP_REM,  32'h0000_0007, 32'hFFFF_FFFE, 32'h0000_0001, 34, 1'b0);
        run_op("div 5/0",       OP_DIV,  32'h0000_0005, 32'h0000_0000, 32'hFFFF_FFFF, 2,  1'b0);
        run_op("rem 5/0",       OP_REM,  32'h0000_0005, 32'h0000_0000, 32'h0000_0005, 2,  1'b0);
        run_op("div min/-1",    OP_DIV,  32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 34, 1'b0);
        run_op("rem min/-1",    OP_REM,  32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 34, 1'b0);

        // Starts while busy and during DONE are ignored; the one in the next IDLE cycle runs.
        op_i = OP_MUL; data1_i = 32'd3; data2_i = 32'd4; start_i = 1'b1;
        step();
        first_at = 0; second_at = 0; done_cnt = 0;
        first_data = '0; second_data = '0;
        for (int k = 1; k <= 80; k++) begin
            if (done_o) begin
                done_cnt++;
                if (first_at == 0) begin first_at = k; first_data = data_o; end
                else begin second_at = k; second_data = data_o; end
            end
            if (k == 35) check("restart idle busy", {31'b0, busy_o}, 32'h0);
            start_i = (k == 5 || k == 34 || k == 35);
            op_i = OP_DIV; data1_i = 32'd100; data2_i = 32'd7;
            step();
        end
        start_i = 1'b0;
        check("restart first done", 32'(first_at), 32'd34);
        check("restart first data", first_data, 32'h0000_000C);
        check("restart second done", 32'(second_at), 32'd69);
        check("restart second data", second_data, 32'h0000_000E);
        check("restart done count", 32'(done_cnt), 32'd2);

        // Reset in CALC aborts the operation silently.
        op_i = OP_MUL; data1_i = 32'd9; data2_i = 32'd9; start_i = 1'b1;
        step();
        start_i = 1'b0;
        for (int k = 1; k < 10; k++) step();
        check("abort busy before", {31'b0, busy_o}, 32'h1);
        rst_i = 1'b1;
        step();
        rst_i = 1'b0;
        check("abort data", data_o, 32'h0);
        check("abort busy", {31'b0, busy_o}, 32'h0);
        done_cnt = 0;
        for (int k = 0; k < 40; k++) begin
            if (done_o) done_cnt++;
            step();
        end
        check("abort no done", 32'(done_cnt), 32'h0);

        // A start coinciding with reset is dropped.
        rst_i = 1'b1; start_i = 1'b1;
        step();
        rst_i = 1'b0; start_i = 1'b0;
        check("start under reset", {31'b0, busy_o}, 32'h0);
        run_op("after reset", OP_MUL, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0001, 34, 1'b0);

        for (int i = 0; i < 150; i++) begin
            op = 2'($urandom_range(0, 3));
            a  = pick();
            b  = pick();
            run_op($sformatf("rand%0d op%0d %h,%h", i, op, a, b), op, a, b, model(op, a, b),
                   (op[1] && b == 0) ? 2 : XLEN + 2, 1'b1);
        end

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
